// File: rtl/seq_pkg.sv
// Shared types and constants for the bit-serial pattern scan controller.
package seq_pkg;

    localparam int unsigned PAT_W  = 4;
    localparam int unsigned FILL_W = 3;

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    // Controller states; the unused code 2'b11 recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_t;

    // Match configuration captured when a job is accepted.
    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic             overlap;
    } match_cfg_t;

    // History fill level after one more bit, saturating at a full window.
    function automatic logic [FILL_W-1:0] fill_next(input logic [FILL_W-1:0] f);
        if (f >= FILL_MAX) begin
            return FILL_MAX;
        end
        return f + FILL_W'(1);
    endfunction

endpackage

// File: rtl/pattern_match4.sv
// Bit-serial 4-bit pattern detector with optional overlapping-match reuse.
module pattern_match4
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  history_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    // Window after the incoming bit and the hit it would produce.
    always_comb begin
        history_nxt = {history[PAT_W-2:0], bit_in};
        fill_nxt    = fill_next(fill);
        hit         = bit_en && (fill_nxt == FILL_MAX) && (history_nxt == pattern);
    end

    // History/fill update; a non-overlapping hit discards the matched bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clr) begin
            history <= '0;
            fill    <= '0;
        end else if (bit_en) begin
            if (hit && !overlap) begin
                history <= '0;
                fill    <= '0;
            end else begin
                history <= history_nxt;
                fill    <= fill_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word and pattern, scans the word MSB-first through the
// pattern detector and returns the saturating hit count.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WORD_W-1:0] word_in,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              bit_en;
    logic              hit;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx;
    match_cfg_t        cfg_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded controls; outputs depend on state only.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        bit_en      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bit_en = 1'b1;
                if (idx == '0) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job capture, bit index countdown and saturating hit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q      <= '0;
            idx         <= '0;
            cfg_q       <= '0;
            match_count <= '0;
        end else if (accept) begin
            word_q        <= word_in;
            idx           <= IDX_TOP;
            cfg_q.pattern <= pattern;
            cfg_q.overlap <= overlap;
            match_count   <= '0;
        end else if (bit_en) begin
            if (idx != '0) begin
                idx <= idx - IDX_W'(1);
            end
            if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    // Sequence detector fed one word bit per SHIFT cycle.
    pattern_match4 u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .bit_en  (bit_en),
        .bit_in  (word_q[idx]),
        .pattern (cfg_q.pattern),
        .overlap (cfg_q.overlap),
        .hit     (hit)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl (CNT_W=4 and a saturating CNT_W=2 copy).
module tb_seq_scan_ctrl;

    localparam int unsigned WORD_W = 8;
    localparam int WW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_valid = 1'b0;
    logic [7:0] word_in = '0;
    logic [3:0] pattern = '0;
    logic       overlap = 1'b0;
    logic       res_ready = 1'b1;

    logic       start_ready, res_valid, busy;
    logic [3:0] match_count;
    logic       s_start_ready, s_res_valid, s_busy;
    logic [1:0] s_match_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .word_in(word_in), .pattern(pattern), .overlap(overlap), .res_valid(res_valid),
        .res_ready(res_ready), .match_count(match_count), .busy(busy)
    );

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(s_start_ready),
        .word_in(word_in), .pattern(pattern), .overlap(overlap), .res_valid(s_res_valid),
        .res_ready(res_ready), .match_count(s_match_count), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: slide a 4-bit window over the word MSB-first; on a
    // non-overlapping match the next window starts after the matched bits.
    function automatic int ref_hits(input logic [7:0] w, input logic [3:0] p, input logic ov);
        int n;
        int s;
        logic [3:0] v;
        n = 0;
        s = 0;
        while (s <= WW - 4) begin
            v = 4'(w >> (WW - 4 - s));
            if (v == p) begin
                n++;
                s += ov ? 1 : 4;
            end else begin
                s++;
            end
        end
        return n;
    endfunction

    function automatic int sat(input int h, input int maxc);
        return (h > maxc) ? maxc : h;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ":start_ready"}, 32'(start_ready), 1);
        check({tag, ":res_valid"}, 32'(res_valid), 0);
        check({tag, ":busy"}, 32'(busy), 0);
        check({tag, ":count"}, 32'(match_count), 0);
        check({tag, ":sat_ready"}, 32'(s_start_ready), 1);
        check({tag, ":sat_valid"}, 32'(s_res_valid), 0);
        check({tag, ":sat_count"}, 32'(s_match_count), 0);
    endtask

    // One job: accept, measure latency, check both counts, optional REPORT stall.
    task automatic run_job(input logic [7:0] w, input logic [3:0] p, input logic ov,
                           input int stall, input string tag);
        int h;
        int cyc;
        h = ref_hits(w, p, ov);
        check({tag, ":idle_ready"}, 32'(start_ready), 1);
        start_valid = 1'b1;
        word_in     = w;
        pattern     = p;
        overlap     = ov;
        res_ready   = (stall == 0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        word_in     = 8'($urandom);
        pattern     = 4'($urandom);
        overlap     = 1'($urandom);
        check({tag, ":busy"}, 32'(busy), 1);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ":latency"}, 32'(cyc), WORD_W);
        check({tag, ":sat_valid"}, 32'(s_res_valid), 1);
        check({tag, ":count"}, 32'(match_count), 32'(sat(h, 15)));
        check({tag, ":sat_count"}, 32'(s_match_count), 32'(sat(h, 3)));
        if (stall > 0) begin
            start_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check({tag, ":stall_valid"}, 32'(res_valid), 1);
                check({tag, ":stall_ready"}, 32'(start_ready), 0);
                check({tag, ":stall_count"}, 32'(match_count), 32'(sat(h, 15)));
            end
            start_valid = 1'b0;
            res_ready   = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, ":done_valid"}, 32'(res_valid), 0);
        check({tag, ":done_ready"}, 32'(start_ready), 1);
    endtask

    initial begin
        logic [7:0] w;
        logic [3:0] p;
        logic       ov;
        bit         seen;

        #12;
        check_reset_vals("in_reset");
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("idle");

        run_job(8'b1010_1010, 4'b1010, 1'b1, 0, "aa_ov");
        run_job(8'b1010_1010, 4'b1010, 1'b0, 0, "aa_nov");
        run_job(8'hFF, 4'b1111, 1'b1, 0, "ff_ov");
        run_job(8'hFF, 4'b1111, 1'b0, 0, "ff_nov");
        run_job(8'b0001_0000, 4'b0001, 1'b1, 0, "first3");
        run_job(8'b0000_0001, 4'b0001, 1'b0, 0, "lastbit");
        run_job(8'b1010_1010, 4'b1010, 1'b1, 5, "stall");
        run_job(8'hFF, 4'b1111, 1'b1, 0, "b2b");

        // Reset asserted mid-scan after four bits.
        start_valid = 1'b1;
        word_in     = 8'hFF;
        pattern     = 4'b1111;
        overlap     = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid || s_res_valid) seen = 1'b1;
        end
        check("no_result_after_reset", 32'(seen), 0);
        run_job(8'b1011_1011, 4'b1011, 1'b1, 0, "post_reset");

        // Randomized jobs; half use a pattern taken from the word itself.
        for (int k = 0; k < 24; k++) begin
            w  = 8'($urandom);
            ov = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                p = 4'(w >> $urandom_range(0, 4));
            end else begin
                p = 4'($urandom);
            end
            run_job(w, p, ov, (k % 6 == 5) ? int'($urandom_range(1, 4)) : 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
